// File: rtl/fir_data_writer.sv
// Ingest stage of the FIR datapath: zero-fills the circular data RAM at run start,
// then stores one AXI-Stream sample at a time and hands its address to the MAC engine.
module fir_data_writer #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_NUM    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  output logic                   busy,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] fir_start_address,
  output logic                   sample_valid,
  input  logic                   compute_done,
  output logic                   last_sample,
  output logic [9:0]             sample_count,
  output logic                   done
);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, WRITE, HANDOFF, DONE} state_t;

  localparam logic [pADDR_WIDTH-1:0] ADDR_STEP = pADDR_WIDTH'(4);
  localparam logic [pADDR_WIDTH-1:0] LAST_ADDR = pADDR_WIDTH'((pTAP_NUM - 1) * 4);
  localparam logic [pADDR_WIDTH-1:0] LAST_PTR  = pADDR_WIDTH'(pTAP_NUM - 1);

  state_t                 state;
  logic [pADDR_WIDTH-1:0] clear_ptr;
  logic [pADDR_WIDTH-1:0] wr_addr;

  // Every output is a register loaded alongside the state transition that implies it,
  // so each output already holds the value belonging to the state being entered.
  // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
  // NOTE: the data RAM itself has no reset; the CLEAR pass is what zeroes its history.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state             <= IDLE;
      clear_ptr         <= '0;
      wr_addr           <= '0;
      busy              <= 1'b0;
      ss_tready         <= 1'b0;
      data_EN           <= 1'b0;
      data_WE           <= 4'h0;
      data_A            <= '0;
      data_Di           <= '0;
      fir_start_address <= '0;
      sample_valid      <= 1'b0;
      last_sample       <= 1'b0;
      sample_count      <= '0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state        <= CLEAR;
            clear_ptr    <= '0;
            wr_addr      <= '0;
            sample_count <= '0;
            busy         <= 1'b1;
            data_EN      <= 1'b1;
            data_WE      <= 4'hF;
            data_A       <= '0;
            data_Di      <= '0;
          end
        end

        CLEAR: begin
          if (clear_ptr == LAST_PTR) begin
            state     <= WAIT_IN;
            data_EN   <= 1'b0;
            data_WE   <= 4'h0;
            data_A    <= '0;
            ss_tready <= 1'b1;
          end else begin
            clear_ptr <= clear_ptr + pADDR_WIDTH'(1);
            data_A    <= (clear_ptr + pADDR_WIDTH'(1)) << 2;
          end
        end

        WAIT_IN: begin
          if (ss_tvalid) begin
            state       <= WRITE;
            ss_tready   <= 1'b0;
            last_sample <= ss_tlast;
            data_EN     <= 1'b1;
            data_WE     <= 4'hF;
            data_A      <= wr_addr;
            data_Di     <= ss_tdata;
          end
        end

        WRITE: begin
          state             <= HANDOFF;
          fir_start_address <= wr_addr;
          sample_valid      <= 1'b1;
          data_EN           <= 1'b0;
          data_WE           <= 4'h0;
          data_A            <= '0;
          data_Di           <= '0;
        end

        HANDOFF: begin
          if (compute_done) begin
            // Upward with wrap, mirroring the address generator's downward walk.
            wr_addr      <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_STEP;
            sample_count <= sample_count + 10'd1;
            sample_valid <= 1'b0;
            if (last_sample) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= WAIT_IN;
              ss_tready <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_data_writer.sv
// Directed bench for fir_data_writer: reset, RAM zero-fill, streaming with address
// wrap, back-pressure during a long MAC pass, ignored inputs and end-of-run.
module tb_fir_data_writer;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start;
  logic          busy;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          data_EN;
  logic [3:0]    data_WE;
  logic [AW-1:0] data_A;
  logic [DW-1:0] data_Di;
  logic [AW-1:0] fir_start_address;
  logic          sample_valid;
  logic          compute_done;
  logic          last_sample;
  logic [9:0]    sample_count;
  logic          done;

  logic [75:0]   outs;
  int            checks = 0;
  int            passes = 0;
  int            exp_addr;
  int            exp_count;

  assign outs = {busy, ss_tready, data_EN, data_WE, data_A, data_Di, fir_start_address,
                 sample_valid, last_sample, sample_count, done};

  always #5 clk = ~clk;

  fir_data_writer dut (
    .axis_clk          (clk),
    .axis_rst          (rst),
    .ap_start          (ap_start),
    .busy              (busy),
    .ss_tvalid         (ss_tvalid),
    .ss_tdata          (ss_tdata),
    .ss_tlast          (ss_tlast),
    .ss_tready         (ss_tready),
    .data_EN           (data_EN),
    .data_WE           (data_WE),
    .data_A            (data_A),
    .data_Di           (data_Di),
    .fir_start_address (fir_start_address),
    .sample_valid      (sample_valid),
    .compute_done      (compute_done),
    .last_sample       (last_sample),
    .sample_count      (sample_count),
    .done              (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0;
    ss_tlast = 1'b0; compute_done = 1'b0;
    step(); step();
    checks++;
    if (outs !== 76'd0) $display("FAIL reset_outs: got %h want 0", outs);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (outs !== 76'd0) $display("FAIL idle_after_reset: got %h want 0", outs);
    else passes++;
  endtask

  task automatic test_mid_clear_reset();
    ap_start = 1'b1; step(); ap_start = 1'b0;
    repeat (5) step();
    checks++;
    if ({data_EN, data_A} !== {1'b1, 12'h014})
      $display("FAIL clear_ptr5: got en=%b a=%h want en=1 a=014", data_EN, data_A);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== 76'd0) $display("FAIL mid_clear_reset: got %h want 0", outs);
    else passes++;
    step(); #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, data_EN} !== 2'b00)
        $display("FAIL post_reset_idle%0d: got busy=%b en=%b want 0 0", i, busy, data_EN);
      else passes++;
    end
  endtask

  task automatic test_clear();
    ap_start = 1'b1; step(); ap_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({data_EN, data_WE, data_A, data_Di, busy, ss_tready} !==
          {1'b1, 4'hF, AW'(i * 4), {DW{1'b0}}, 1'b1, 1'b0})
        $display("FAIL clear_write%0d: got en=%b we=%h a=%h di=%h busy=%b rdy=%b want en=1 we=f a=%h di=0 busy=1 rdy=0",
                 i, data_EN, data_WE, data_A, data_Di, busy, ss_tready, AW'(i * 4));
      else passes++;
      step();
    end
    checks++;
    if ({ss_tready, data_EN, data_WE} !== {1'b1, 1'b0, 4'h0})
      $display("FAIL clear_end: got rdy=%b en=%b we=%h want rdy=1 en=0 we=0",
               ss_tready, data_EN, data_WE);
    else passes++;
    exp_addr = 0; exp_count = 0;
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic last, input int delay,
                             input logic hold);
    int n = 0;
    while (ss_tready !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (ss_tready !== 1'b1) $display("FAIL ready_timeout: got rdy=%b want 1", ss_tready);
    else passes++;
    ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = last;
    step();
    if (hold) ss_tdata = ~d;
    else ss_tvalid = 1'b0;
    checks++;
    if ({data_EN, data_WE, data_A, data_Di, ss_tready} !==
        {1'b1, 4'hF, AW'(exp_addr), d, 1'b0})
      $display("FAIL sample_write: got en=%b we=%h a=%h di=%h rdy=%b want en=1 we=f a=%h di=%h rdy=0",
               data_EN, data_WE, data_A, data_Di, ss_tready, AW'(exp_addr), d);
    else passes++;
    step();
    checks++;
    if ({sample_valid, fir_start_address, data_EN, ss_tready} !==
        {1'b1, AW'(exp_addr), 1'b0, 1'b0})
      $display("FAIL handoff_entry: got sv=%b fsa=%h en=%b rdy=%b want sv=1 fsa=%h en=0 rdy=0",
               sample_valid, fir_start_address, data_EN, ss_tready, AW'(exp_addr));
    else passes++;
    for (int i = 1; i < delay; i++) begin
      step();
      checks++;
      if ({sample_valid, fir_start_address, data_EN, ss_tready} !==
          {1'b1, AW'(exp_addr), 1'b0, 1'b0})
        $display("FAIL handoff_hold%0d: got sv=%b fsa=%h en=%b rdy=%b want sv=1 fsa=%h en=0 rdy=0",
                 i, sample_valid, fir_start_address, data_EN, ss_tready, AW'(exp_addr));
      else passes++;
    end
    compute_done = 1'b1;
    step();
    compute_done = 1'b0; ss_tvalid = 1'b0;
    exp_addr  = (exp_addr == 40) ? 0 : exp_addr + 4;
    exp_count = exp_count + 1;
    checks++;
    if ({sample_valid, sample_count, last_sample, done, ss_tready} !==
        {1'b0, 10'(exp_count), last, last, ~last})
      $display("FAIL after_done: got sv=%b cnt=%0d last=%b done=%b rdy=%b want sv=0 cnt=%0d last=%b done=%b rdy=%b",
               sample_valid, sample_count, last_sample, done, ss_tready,
               exp_count, last, last, ~last);
    else passes++;
  endtask

  task automatic test_stream();
    for (int s = 1; s <= 12; s++) send_sample(DW'(s), 1'b0, 2, 1'b0);
  endtask

  task automatic test_back_pressure();
    send_sample(32'hCAFE_0013, 1'b0, 20, 1'b1);
  endtask

  task automatic test_ignored();
    ap_start = 1'b1; compute_done = 1'b1;
    step();
    ap_start = 1'b0; compute_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ss_tready, busy, data_EN, sample_valid, sample_count} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 10'(exp_count)})
        $display("FAIL ignored%0d: got rdy=%b busy=%b en=%b sv=%b cnt=%0d want 1 1 0 0 %0d",
                 i, ss_tready, busy, data_EN, sample_valid, sample_count, exp_count);
      else passes++;
      step();
    end
  endtask

  task automatic test_last();
    int fsa;
    fsa = exp_addr;
    send_sample(32'h0000_0E0E, 1'b1, 2, 1'b0);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_in_done: got %b want 1", busy);
    else passes++;
    step();
    checks++;
    if ({done, busy, sample_count, fir_start_address} !==
        {1'b0, 1'b0, 10'(exp_count), AW'(fsa)})
      $display("FAIL end_of_run: got done=%b busy=%b cnt=%0d fsa=%h want 0 0 %0d %h",
               done, busy, sample_count, fir_start_address, exp_count, AW'(fsa));
    else passes++;
    ss_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ss_tready, data_EN, busy} !== 3'b000)
        $display("FAIL post_run_valid%0d: got rdy=%b en=%b busy=%b want 0 0 0",
                 i, ss_tready, data_EN, busy);
      else passes++;
    end
    ss_tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mid_clear_reset();
    test_clear();
    test_stream();
    test_back_pressure();
    test_ignored();
    test_last();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_data_writer.md
# fir_data_writer

Ingest side of the FIR datapath: accepts input samples on an AXI-Stream slave port and writes them into the 11-entry circular data RAM. Publishes the newest-sample address to the FIR address generator, then holds off further input until that engine signals its MAC pass is complete. It also zero-fills the data RAM at the start of every run, so the first outputs see zero history.

## Interface
- pADDR_WIDTH, 12, RAM byte-address width
- pDATA_WIDTH, 32, sample width
- pTAP_NUM, 11, data RAM depth in words; byte addresses 0x000..0x028 step 4
- axis_clk  in  1  sole clock, rising edge
- axis_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  start request, sampled only in IDLE
- busy  out  1  high in every state except IDLE
- ss_tvalid  in  1  input sample valid
- ss_tdata  in  pDATA_WIDTH  input sample
- ss_tlast  in  1  marks final sample of the run
- ss_tready  out  1  high exactly in WAIT_IN
- data_EN  out  1  RAM enable
- data_WE  out  4  RAM byte write enables; 4'hF or 4'h0
- data_A  out  pADDR_WIDTH  RAM write byte address
- data_Di  out  pDATA_WIDTH  RAM write data
- fir_start_address  out  pADDR_WIDTH  address of newest stored sample
- sample_valid  out  1  newest sample stored; compute may run
- compute_done  in  1  one-cycle pulse from the address generator when its MAC loop finishes
- last_sample  out  1  captured ss_tlast of the current sample
- sample_count  out  10  samples fully processed this run
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, CLEAR, WAIT_IN, WRITE, HANDOFF, DONE. Outputs are decoded from registered state and internal registers only; there is no combinational path from any input to any output.
- IDLE: if ap_start, clear_ptr<=0, sample_count<=0, wr_addr<=0x000, then go to CLEAR. Otherwise remain.
- CLEAR: data_EN=1, data_WE=4'hF, data_Di=0, data_A=clear_ptr*4.
  - clear_ptr increments each cycle.
  - After the write at 0x028, go to WAIT_IN.
- WAIT_IN: ss_tready=1. On ss_tvalid&ss_tready at a clock edge, capture ss_tdata into sample_reg and ss_tlast into last_sample, then go to WRITE.
- WRITE: data_EN=1, data_WE=4'hF, data_A=wr_addr, data_Di=sample_reg. Set fir_start_address<=wr_addr, then go to HANDOFF.
- HANDOFF: sample_valid=1. On compute_done:
  - wr_addr <= (wr_addr==0x028) ? 0x000 : wr_addr+4
  - sample_count++
  - go to DONE if last_sample, else WAIT_IN.
- DONE: done=1 for one cycle, then go to IDLE. fir_start_address and sample_count hold until the next ap_start.
- The address generator reads newest-to-oldest by decrementing from fir_start_address with wrap 0x000→0x028. The writer must therefore advance upward with wrap 0x028→0x000.
- Outside CLEAR/WRITE: data_EN=0, data_WE=0, data_A=0, data_Di=0.
- Ignored inputs:
  - ap_start outside IDLE.
  - compute_done outside HANDOFF.
  - ss_tvalid outside WAIT_IN; the sample stays pending at the source.
- sample_count wraps at 1023→0 without a flag.

## Timing
- Reset (async assert, synchronous release) values:
  - state=IDLE.
  - busy, ss_tready, data_EN, sample_valid, last_sample, done = 0.
  - data_WE=0, data_A=0, data_Di=0, fir_start_address=0, sample_count=0.
- Reset asserted mid-run: immediate return to IDLE. Clearing is not resumed, and the RAM contents left behind are don't-care. A new ap_start is required.
- ap_start high at edge N → CLEAR from N. The 11 zero writes occur in cycles N..N+10. WAIT_IN is entered at edge N+11.
- A stream transfer at edge T gives a RAM write during cycle T..T+1. sample_valid is high from edge T+1 until the edge on which compute_done is sampled.
- compute_done sampled at edge C: sample_valid and fir_start_address stable through C. ss_tready is high again from C, so the next transfer can occur at edge C+1.
- Minimum per-sample period: 3 cycles (WAIT_IN, WRITE, HANDOFF with compute_done in its first cycle).
- compute_done coinciding with entry into HANDOFF (the WRITE→HANDOFF edge) is not seen. It must be sampled while the state is HANDOFF.

## Test plan
- Reset mid-CLEAR (assert axis_rst at clear_ptr=5) → all outputs at reset values within the same cycle, state=IDLE, no further RAM writes.
- ap_start, then monitor the RAM port → exactly 11 writes of 0 to 0x000,0x004,…,0x028 on consecutive cycles, followed by ss_tready=1.
- Feed samples 1..12, compute_done 2 cycles after each sample_valid rise → writes go to 0x000..0x028 then wrap to 0x000 (sample 12). fir_start_address values follow the same sequence.
- ss_tvalid held high with compute_done delayed 20 cycles → ss_tready=0 throughout HANDOFF, no second write, sample_valid held for 20 cycles.
- Sample with ss_tlast=1 → after its compute_done: sample_count=N, done pulses one cycle, busy falls. A subsequent ss_tvalid is not accepted.
- ap_start pulsed during WAIT_IN, and compute_done pulsed during WAIT_IN → no state change, no RAM write, sample_count unchanged.
